// File: rtl/axi_line_fill_pkg.sv
// Shared AXI and instruction-cache definitions for the line-fill engine.
package axi_line_fill_pkg;

    localparam int AXI_DATA_WIDTH    = 32;
    localparam int ICACHE_LINE_SIZE  = 32;
    localparam int ICACHE_LINE_BEATS = ICACHE_LINE_SIZE * 8 / AXI_DATA_WIDTH;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_type_t;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [2:0] {
        AXI_SIZE_1B   = 3'd0,
        AXI_SIZE_2B   = 3'd1,
        AXI_SIZE_4B   = 3'd2,
        AXI_SIZE_8B   = 3'd3,
        AXI_SIZE_16B  = 3'd4,
        AXI_SIZE_32B  = 3'd5,
        AXI_SIZE_64B  = 3'd6,
        AXI_SIZE_128B = 3'd7
    } axi_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } fill_state_t;

endpackage

// File: rtl/axi_line_fill.sv
// Cache line fill engine: issues one AXI read burst (INCR or critical-word-first WRAP)
// and assembles the returned beats into a full line, flagging protocol/response errors.
module axi_line_fill
    import axi_line_fill_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = AXI_DATA_WIDTH,
    parameter int ID_W       = 4,
    parameter int LINE_BYTES = ICACHE_LINE_SIZE,
    parameter int FILL_ID    = 0,
    localparam int BEATS     = LINE_BYTES * 8 / DATA_W,
    localparam int IDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic                    req_wrap,
    output logic                    word_valid,
    output logic [DATA_W-1:0]       word_data,
    output logic [IDX_W-1:0]        word_idx,
    output logic [LINE_BYTES*8-1:0] line_data,
    output logic                    done,
    output logic                    err,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [ADDR_W-1:0]       araddr,
    output logic [ID_W-1:0]         arid,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [DATA_W-1:0]       rdata,
    input  logic [ID_W-1:0]         rid,
    input  logic [1:0]              rresp,
    input  logic                    rlast
);

    localparam int                WORD_LSB  = $clog2(DATA_W / 8);
    localparam int                CNT_W     = $clog2(BEATS + 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(DATA_W / 8 - 1);
    localparam logic [IDX_W-1:0]  IDX_MASK  = IDX_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BEATS - 1);
    localparam axi_size_t         SIZE_ENC  = axi_size_t'(WORD_LSB);

    fill_state_t              state_q, state_d;
    logic [ADDR_W-1:0]        addr_q;
    logic                     wrap_q;
    logic [IDX_W-1:0]         idx_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     err_q;
    logic [LINE_BYTES*8-1:0]  line_q;
    axi_burst_type_t          burst;
    logic                     beat_fire;
    logic                     last_beat;
    logic                     beat_err;
    logic [IDX_W-1:0]         start_idx;

    // Handshakes: a transfer happens on the rising edge where valid and ready are both 1;
    // AR fields come from registers latched at request time, so they cannot move while arvalid waits.
    assign beat_fire = (state_q == DATA) && rvalid;
    assign last_beat = (cnt_q == LAST_CNT) || rlast;
    assign beat_err  = (axi_resp_t'(rresp) != AXI_RESP_OKAY) || (rid != ID_W'(FILL_ID))
                     || (rlast != (cnt_q == LAST_CNT));

    // Critical word first: the wrap starts at the requested word's slot within the line.
    assign start_idx = wrap_q ? (IDX_W'(addr_q >> WORD_LSB) & IDX_MASK) : '0;

    assign burst     = wrap_q ? AXI_BURST_WRAP : AXI_BURST_INCR;
    assign araddr    = wrap_q ? (addr_q & WORD_MASK) : (addr_q & LINE_MASK);
    assign arid      = ID_W'(FILL_ID);
    assign arlen     = 8'(BEATS - 1);
    assign arsize    = SIZE_ENC;
    assign arburst   = burst;
    assign word_data = rdata;
    assign word_idx  = idx_q;
    assign line_data = line_q;
    assign err       = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid) state_d = ADDR;
            ADDR:    if (arready) state_d = DATA;
            DATA:    if (rvalid && last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        word_valid = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            IDLE:    req_ready = 1'b1;
            ADDR:    arvalid = 1'b1;
            DATA:    begin rready = 1'b1; word_valid = rvalid; end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            wrap_q <= 1'b0;
            idx_q  <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            line_q <= '0;
        end else begin
            if (state_q == IDLE && req_valid) begin
                addr_q <= req_addr;
                wrap_q <= req_wrap;
                cnt_q  <= '0;
                err_q  <= 1'b0;
            end
            if (state_q == ADDR && arready) idx_q <= start_idx;
            if (beat_fire) begin
                for (int i = 0; i < BEATS; i++) begin
                    if (idx_q == IDX_W'(i)) line_q[i*DATA_W +: DATA_W] <= rdata;
                end
                idx_q <= (idx_q + 1'b1) & IDX_MASK;
                cnt_q <= cnt_q + 1'b1;
                err_q <= err_q | beat_err;
            end
            if (state_q == DONE) err_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_line_fill.sv
// Bench for axi_line_fill: directed scenarios plus randomized fills against a line-level model.
module tb_axi_line_fill;
    import axi_line_fill_pkg::*;

    localparam int ADDR_W = 32, DATA_W = 32, ID_W = 4, LINE_BYTES = 32, FILL_ID = 0;
    localparam int BEATS = 8, IDX_W = 3;

    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 0, req_ready, req_wrap = 0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic word_valid, done, err, arvalid, arready = 0, rready, rvalid = 0, rlast = 0;
    logic [DATA_W-1:0] word_data, rdata = '0;
    logic [IDX_W-1:0] word_idx;
    logic [LINE_BYTES*8-1:0] line_data;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0] arid, rid = '0;
    logic [7:0] arlen;
    logic [2:0] arsize;
    logic [1:0] arburst, rresp = '0;

    always #5 clk = ~clk;

    axi_line_fill #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LINE_BYTES(LINE_BYTES),
                    .FILL_ID(FILL_ID)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wrap(req_wrap), .word_valid(word_valid), .word_data(word_data),
        .word_idx(word_idx), .line_data(line_data), .done(done), .err(err),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .rid(rid), .rresp(rresp), .rlast(rlast)
    );

    int n_tests = 0, n_fail = 0;
    logic [IDX_W+DATA_W-1:0] exp_q[$], obs_q[$];
    logic [DATA_W-1:0] data_a[BEATS];
    logic [DATA_W-1:0] exp_line[BEATS];

    // Stimulus knobs (beat numbers are 1-based; 0 disables the injection)
    int ar_wait, err_beat, rlast_at, bad_id_beat;
    bit gaps, second_req;

    // Observations from do_fill
    logic [ADDR_W-1:0] o_araddr;
    logic [1:0] o_arburst;
    logic [7:0] o_arlen;
    logic [2:0] o_arsize;
    logic [ID_W-1:0] o_arid;
    logic o_err;
    bit ar_changed, busy_ready;
    int ar_cycles, done_cyc, done_cnt;

    // Model outputs
    logic [ADDR_W-1:0] e_araddr;
    logic [1:0] e_burst;
    logic e_err;
    int e_lat;

    task automatic set_defaults();
        ar_wait = 0; err_beat = 0; rlast_at = BEATS; bad_id_beat = 0; gaps = 0; second_req = 0;
        for (int k = 0; k < BEATS; k++) data_a[k] = $urandom();
    endtask

    task automatic model_fill(input logic [ADDR_W-1:0] a, input logic w);
        int start, n;
        e_araddr = w ? (a / 4) * 4 : (a / LINE_BYTES) * LINE_BYTES;
        e_burst  = w ? 2'b10 : 2'b01;
        start    = w ? int'((a / 4) % BEATS) : 0;
        n        = (rlast_at > BEATS) ? BEATS : rlast_at;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({IDX_W'((start + k) % BEATS), data_a[k]});
            exp_line[(start + k) % BEATS] = data_a[k];
        end
        e_err = (rlast_at != BEATS) || (err_beat >= 1 && err_beat <= n)
              || (bad_id_beat >= 1 && bad_id_beat <= n);
        e_lat = n + 2 + ar_wait;
    endtask

    // Drives one full fill (request, AR, R beats) and records what the DUT did.
    task automatic do_fill(input logic [ADDR_W-1:0] a, input logic w);
        int cyc, sent, n_send;
        bit fin;
        obs_q.delete(); ar_changed = 0; busy_ready = 0; ar_cycles = 0;
        done_cyc = -1; done_cnt = 0; o_err = 1'bx;
        cyc = 0; sent = 0; fin = 0;
        n_send = (rlast_at > BEATS) ? BEATS : rlast_at;
        req_valid = 1; req_addr = a; req_wrap = w; arready = 0; rvalid = 0; rlast = 0;
        while (!fin) begin
            @(negedge clk);
            if (arvalid) begin
                if (ar_cycles == 0) begin
                    o_araddr = araddr; o_arburst = arburst; o_arlen = arlen;
                    o_arsize = arsize; o_arid = arid;
                end else if (araddr !== o_araddr || arburst !== o_arburst || arlen !== o_arlen
                             || arsize !== o_arsize || arid !== o_arid) ar_changed = 1;
                if (req_ready) busy_ready = 1;
                ar_cycles++;
            end
            if (word_valid) obs_q.push_back({word_idx, word_data});
            if (done) begin done_cnt++; done_cyc = cyc; o_err = err; fin = 1; end
            if (rvalid && rready) sent++;
            @(posedge clk); #1; cyc++;
            if (cyc > 300) fin = 1;
            req_valid = second_req && arvalid;
            req_addr  = a ^ 32'h0000_0100;
            req_wrap  = ~w;
            arready   = (ar_cycles >= ar_wait);
            rvalid    = (sent < n_send) && (!gaps || $urandom_range(0, 3) != 0);
            rdata     = data_a[sent % BEATS];
            rlast     = (sent + 1 == rlast_at);
            rresp     = (sent + 1 == err_beat) ? 2'b10 : 2'b00;
            rid       = (sent + 1 == bad_id_beat) ? ID_W'(FILL_ID + 1) : ID_W'(FILL_ID);
        end
        req_valid = 0; arready = 0; rvalid = 0; rlast = 0; rresp = 0; rid = ID_W'(FILL_ID);
    endtask

    task automatic test_reset();
        rst_n = 0; rvalid = 1; req_valid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if ({req_ready, arvalid, rready, word_valid, done, err} !== 6'b100000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b need 100000",
                               {req_ready, arvalid, rready, word_valid, done, err}); end
        n_tests++; if (line_data !== '0) begin n_fail++; $display("FAIL reset_line: got %h need 0", line_data); end
        rvalid = 0; rst_n = 1;
        @(posedge clk); #1;
        for (int i = 0; i < BEATS; i++) exp_line[i] = '0;
    endtask

    task automatic test_incr();
        set_defaults();
        for (int k = 0; k < BEATS; k++) data_a[k] = DATA_W'(32'hA0 + k);
        model_fill(32'h0000_1234, 0);
        do_fill(32'h0000_1234, 0);
        n_tests++; if (o_araddr !== 32'h0000_1220) begin n_fail++; $display("FAIL incr_araddr: got %h need 00001220", o_araddr); end
        n_tests++; if ({o_arburst, o_arlen, o_arsize, o_arid} !== {2'b01, 8'd7, 3'd2, 4'd0}) begin
            n_fail++; $display("FAIL incr_arfields: got %h need %h", {o_arburst, o_arlen, o_arsize, o_arid},
                               {2'b01, 8'd7, 3'd2, 4'd0}); end
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL incr_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL incr_word%0d: got %h need %h", i, obs_q[i], exp_q[i]); end
        end
        for (int i = 0; i < BEATS; i++) begin
            n_tests++; if (line_data[i*DATA_W +: DATA_W] !== DATA_W'(32'hA0 + i)) begin
                n_fail++; $display("FAIL incr_line%0d: got %h need %h", i, line_data[i*DATA_W +: DATA_W], 32'hA0 + i); end
        end
        n_tests++; if (done_cyc != 10 || done_cnt != 1) begin n_fail++; $display("FAIL incr_latency: got %0d (pulses %0d) need 10", done_cyc, done_cnt); end
        n_tests++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL incr_err: got %b need 0", o_err); end
        @(negedge clk);
        n_tests++; if ({done, req_ready, err} !== 3'b010) begin n_fail++; $display("FAIL incr_after_done: got %b need 010", {done, req_ready, err}); end
    endtask

    task automatic test_wrap();
        set_defaults();
        model_fill(32'h0000_1234, 1);
        do_fill(32'h0000_1234, 1);
        n_tests++; if (o_araddr !== 32'h0000_1234 || o_arburst !== 2'b10) begin
            n_fail++; $display("FAIL wrap_ar: got %h/%b need 00001234/10", o_araddr, o_arburst); end
        n_tests++; if (obs_q.size() != BEATS) begin n_fail++; $display("FAIL wrap_count: got %0d need %0d", obs_q.size(), BEATS); end
        for (int i = 0; i < BEATS && i < obs_q.size(); i++) begin
            n_tests++; if (obs_q[i] !== exp_q[i] || obs_q[i][DATA_W +: IDX_W] !== IDX_W'((5 + i) % 8)) begin
                n_fail++; $display("FAIL wrap_word%0d: got %h need %h", i, obs_q[i], exp_q[i]); end
        end
        for (int i = 0; i < BEATS; i++) begin
            n_tests++; if (line_data[i*DATA_W +: DATA_W] !== exp_line[i]) begin
                n_fail++; $display("FAIL wrap_line%0d: got %h need %h", i, line_data[i*DATA_W +: DATA_W], exp_line[i]); end
        end
        n_tests++; if (o_err !== 1'b0 || done_cyc != 10) begin n_fail++; $display("FAIL wrap_done: got err %b cyc %0d need 0/10", o_err, done_cyc); end
    endtask

    task automatic test_ar_stall();
        logic [ADDR_W-1:0] a;
        bit extra;
        set_defaults();
        ar_wait = 10; second_req = 1; a = $urandom();
        model_fill(a, 0);
        do_fill(a, 0);
        n_tests++; if (ar_cycles != 11) begin n_fail++; $display("FAIL stall_arvalid_cycles: got %0d need 11", ar_cycles); end
        n_tests++; if (ar_changed) begin n_fail++; $display("FAIL stall_ar_stable: got changed need stable"); end
        n_tests++; if (busy_ready) begin n_fail++; $display("FAIL stall_req_ready: got 1 need 0"); end
        n_tests++; if (o_araddr !== e_araddr) begin n_fail++; $display("FAIL stall_araddr: got %h need %h", o_araddr, e_araddr); end
        n_tests++; if (obs_q != exp_q) begin n_fail++; $display("FAIL stall_stream: got %0d words need %0d", obs_q.size(), exp_q.size()); end
        n_tests++; if (done_cyc != e_lat || done_cnt != 1) begin n_fail++; $display("FAIL stall_latency: got %0d need %0d", done_cyc, e_lat); end
        extra = 0;
        repeat (4) begin @(negedge clk); if (arvalid || done) extra = 1; end
        n_tests++; if (extra) begin n_fail++; $display("FAIL stall_second_req: got extra burst need none"); end
    endtask

    task automatic test_resp_err();
        for (int v = 0; v < 2; v++) begin
            set_defaults();
            if (v == 0) err_beat = 3; else bad_id_beat = $urandom_range(1, BEATS);
            model_fill(32'h0000_4000 + 32'($urandom_range(0, 255)), 1'(v));
            do_fill(32'h0000_4000 + 32'($urandom_range(0, 255)) & 32'hFFFF_FFE0 | 32'(e_araddr[4:0]), 1'(v));
            n_tests++; if (obs_q.size() != BEATS) begin n_fail++; $display("FAIL resperr%0d_count: got %0d need %0d", v, obs_q.size(), BEATS); end
            n_tests++; if (done_cnt != 1 || o_err !== 1'b1) begin n_fail++; $display("FAIL resperr%0d_err: got %b (pulses %0d) need 1", v, o_err, done_cnt); end
        end
    endtask

    task automatic test_early_rlast();
        int cases[3] = '{6, 9, 1};
        logic [ADDR_W-1:0] a;
        for (int v = 0; v < 3; v++) begin
            set_defaults();
            rlast_at = cases[v]; a = $urandom();
            model_fill(a, 0);
            do_fill(a, 0);
            n_tests++; if (obs_q != exp_q) begin n_fail++; $display("FAIL rlast%0d_stream: got %0d words need %0d", rlast_at, obs_q.size(), exp_q.size()); end
            n_tests++; if (done_cyc != e_lat || o_err !== 1'b1) begin
                n_fail++; $display("FAIL rlast%0d_done: got cyc %0d err %b need %0d/1", rlast_at, done_cyc, o_err, e_lat); end
            for (int i = 0; i < BEATS; i++) begin
                n_tests++; if (line_data[i*DATA_W +: DATA_W] !== exp_line[i]) begin
                    n_fail++; $display("FAIL rlast%0d_line%0d: got %h need %h", rlast_at, i, line_data[i*DATA_W +: DATA_W], exp_line[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int sent, guard;
        bit saw_done;
        set_defaults();
        req_valid = 1; req_addr = $urandom(); req_wrap = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        req_valid = 0; arready = 1; rvalid = 1; rdata = data_a[0]; rlast = 0; rresp = 0; rid = ID_W'(FILL_ID);
        sent = 0; guard = 0;
        while (sent < 4 && guard < 50) begin
            @(negedge clk); if (rvalid && rready) sent++;
            @(posedge clk); #1; guard++; rdata = data_a[sent];
        end
        n_tests++; if (sent != 4) begin n_fail++; $display("FAIL rstmid_beats: got %0d need 4", sent); end
        rst_n = 0; #1;
        n_tests++; if ({arvalid, rready, done} !== 3'b000) begin n_fail++; $display("FAIL rstmid_async: got %b need 000", {arvalid, rready, done}); end
        saw_done = 0;
        repeat (3) begin @(negedge clk); if (done) saw_done = 1; end
        rst_n = 1; rvalid = 0; arready = 0;
        @(posedge clk); #1;
        if (done) saw_done = 1;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_req_ready: got %b need 1", req_ready); end
        n_tests++; if (saw_done) begin n_fail++; $display("FAIL rstmid_no_done: got pulse need none"); end
        n_tests++; if (line_data !== '0) begin n_fail++; $display("FAIL rstmid_line_clr: got %h need 0", line_data); end
        for (int i = 0; i < BEATS; i++) exp_line[i] = '0;
        set_defaults();
        model_fill(32'h0000_1234, 0);
        do_fill(32'h0000_1234, 0);
        n_tests++; if (obs_q != exp_q || done_cnt != 1 || o_err !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_refill: got %0d words err %b need %0d words err 0", obs_q.size(), o_err, exp_q.size()); end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a;
        logic w;
        for (int it = 0; it < 24; it++) begin
            set_defaults();
            a = $urandom(); w = 1'($urandom_range(0, 1));
            ar_wait = $urandom_range(0, 3); gaps = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                1: err_beat = $urandom_range(1, BEATS);
                2: rlast_at = $urandom_range(1, BEATS + 1);
                3: bad_id_beat = $urandom_range(1, BEATS);
                default: ;
            endcase
            model_fill(a, w);
            do_fill(a, w);
            n_tests++; if (o_araddr !== e_araddr || o_arburst !== e_burst) begin
                n_fail++; $display("FAIL rand%0d_ar: got %h/%b need %h/%b", it, o_araddr, o_arburst, e_araddr, e_burst); end
            n_tests++; if (obs_q != exp_q) begin n_fail++; $display("FAIL rand%0d_stream: got %0d words need %0d", it, obs_q.size(), exp_q.size()); end
            n_tests++; if (done_cnt != 1 || o_err !== e_err) begin
                n_fail++; $display("FAIL rand%0d_err: got %b (pulses %0d) need %b", it, o_err, done_cnt, e_err); end
            if (!gaps) begin
                n_tests++; if (done_cyc != e_lat) begin n_fail++; $display("FAIL rand%0d_latency: got %0d need %0d", it, done_cyc, e_lat); end
            end
            for (int i = 0; i < BEATS; i++) begin
                n_tests++; if (line_data[i*DATA_W +: DATA_W] !== exp_line[i]) begin
                    n_fail++; $display("FAIL rand%0d_line%0d: got %h need %h", it, i, line_data[i*DATA_W +: DATA_W], exp_line[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_ar_stall();
        test_resp_err();
        test_early_rlast();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
